fe_mul_arbiter: RTL

//  Shares one field multiply + reduce-mod-p datapath (p = 2^255-19) among NREQ requesters.
//  - Arbitration: round-robin.
//  - Sequencing: FSM issues one operation at a time to the datapath.
//  - Return: routes each reduced result back to the requester that was granted.
//  - Placement: between the point/ladder engines and the shared fe_mul+reduce core.

---
 rtl/fe_pkg.sv | 26 ++
 rtl/fe_rr_arbiter.sv | 48 ++++
 rtl/fe_mul_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fe_pkg.sv
// ============================================================================
// Module   : fe_pkg
// Brief    : Shared field-element types and constants for the p = 2^255-19 cluster.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fe_pkg;

    localparam int N_FE = 255;

    typedef logic [N_FE-1:0] fe_t;

    localparam fe_t P_FE =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage : fe_pkg

`default_nettype wire

// File: rtl/fe_rr_arbiter.sv
// ============================================================================
// Module   : fe_rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after i_ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fe_rr_arbiter
    import fe_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return s[IW-1:0];
    endfunction

    // Scan from the farthest offset down so the nearest request overwrites the choice.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[wrap_add(i_ptr, k)]) begin
                o_any = 1'b1;
                o_idx = wrap_add(i_ptr, k);
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule : fe_rr_arbiter

`default_nettype wire

// File: rtl/fe_mul_arbiter.sv
// ============================================================================
// Module   : fe_mul_arbiter
// Brief    : Round-robin sharing of one fe_mul+reduce datapath among NREQ users.
//            Optional watchdog in WAIT enabled by defining FE_ARB_WDT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fe_mul_arbiter
    import fe_pkg::*;
#(
    parameter int N       = 255,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_r,
    output logic              rsp_err,
    output logic              dp_start,
    output logic [N-1:0]      dp_a,
    output logic [N-1:0]      dp_b,
    input  logic              dp_done,
    input  logic [N-1:0]      dp_r,
    output logic              busy
);

    localparam int            IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] c_LAST_IDX = IW'(NREQ - 1);

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gid;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_r;
    logic            r_err;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_timeout;

    fe_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

`ifdef FE_ARB_WDT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    // Cleared while launching so the first WAIT cycle counts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
`else
    // No watchdog: WAIT only exits on dp_done.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_gid <= w_idx;
                r_a   <= req_a[int'(w_idx)*N +: N];
                r_b   <= req_b[int'(w_idx)*N +: N];
                r_ptr <= (w_idx == c_LAST_IDX) ? '0 : w_idx + 1'b1;
            end
            // dp_done takes priority over an expiring watchdog in the same cycle.
            if (r_state == WAIT) begin
                if (dp_done) begin
                    r_r   <= dp_r;
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_r   <= '0;
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (dp_done || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        dp_start  = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE:    if (rst_n) req_ready = w_gnt;
            ISSUE:   dp_start = 1'b1;
            RESP: begin
                rsp_valid[r_gid] = 1'b1;
                rsp_err          = r_err;
            end
            default: ;
        endcase
    end

    assign rsp_r = r_r;
    assign dp_a  = r_a;
    assign dp_b  = r_b;

endmodule : fe_mul_arbiter

`default_nettype wire
